// File: rtl/led_share_arbiter.sv
// led_share_arbiter: round-robin time-sliced sharing of one LED among four requesters
module led_share_arbiter #(
  parameter int HOLD_CYCLES = 25000000,
  parameter int GAP_CYCLES  = 2
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic [3:0] i_Req,
  input  logic [3:0] i_Data,
  output logic [3:0] o_Grant,
  output logic       o_LED,
  output logic       o_Busy
);
  localparam int CW = $clog2(HOLD_CYCLES + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(HOLD_CYCLES - 1);
  localparam logic [GW-1:0] GAP_MAX = GW'(GAP_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;
  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [GW-1:0] gap_cnt, gap_nxt;
  logic [1:0]    owner, owner_nxt, last, last_nxt, win;
  logic [3:0]    grant_nxt;
  logic          led_nxt, slice_end;
  assign o_Busy    = state != IDLE;
  assign slice_end = (cnt == CNT_MAX) && |(i_Req & ~o_Grant);
  // round-robin pick: scan from last+1 round to last, first requester found wins
  always_comb begin
    win = last;
    for (int k = 3; k >= 0; k--)
      if (i_Req[last + 2'(k + 1)]) win = last + 2'(k + 1);
  end
  // next-state and next-output logic; LED and grant are forced off outside GRANT
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    gap_nxt   = gap_cnt;
    owner_nxt = owner;
    last_nxt  = last;
    grant_nxt = o_Grant;
    led_nxt   = o_LED;
    case (state)
      IDLE: begin
        grant_nxt = 4'b0;
        led_nxt   = 1'b0;
        if (|i_Req) begin
          state_nxt = GRANT;
          owner_nxt = win;
          last_nxt  = win;
          grant_nxt = 4'b0001 << win;
          cnt_nxt   = '0;
        end
      end
      GRANT: begin
        if (!i_Req[owner] || slice_end) begin
          state_nxt = GAP;
          grant_nxt = 4'b0;
          led_nxt   = 1'b0;
          gap_nxt   = '0;
        end else begin
          led_nxt = i_Data[owner];
          cnt_nxt = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
        end
      end
      GAP: begin
        grant_nxt = 4'b0;
        led_nxt   = 1'b0;
        if (gap_cnt == GAP_MAX) state_nxt = IDLE;
        else gap_nxt = gap_cnt + 1'b1;
      end
      default: begin
        state_nxt = IDLE;
        grant_nxt = 4'b0;
        led_nxt   = 1'b0;
      end
    endcase
  end
  // state and datapath registers; reset gives requester 0 first priority
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state   <= IDLE;
      cnt     <= '0;
      gap_cnt <= '0;
      owner   <= 2'd0;
      last    <= 2'd3;
      o_Grant <= 4'b0;
      o_LED   <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      gap_cnt <= gap_nxt;
      owner   <= owner_nxt;
      last    <= last_nxt;
      o_Grant <= grant_nxt;
      o_LED   <= led_nxt;
    end
  end
endmodule
